// File: rtl/clk_tick_gen.sv
// Multi-channel programmable tick / divided-clock generator.
// Each channel counts D cycles per tick; divisor updates are staged and applied at a period boundary.
module clk_tick_gen #(
   parameter  int N_CH           = 4,
   parameter  int DIV_W          = 27,
   parameter  int INPUT_CLK_FREQ = 100_000_000,
   parameter  int DEF_OUT_FREQ   = 10,
   localparam int CH_W           = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   en,
   input  logic              sync_clr,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [DIV_W-1:0]  wr_div,
   output logic              wr_err,
   output logic [N_CH-1:0]   pend,
   output logic [N_CH-1:0]   tick_o,
   output logic [N_CH-1:0]   clk_o
);

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(INPUT_CLK_FREQ / DEF_OUT_FREQ / 2);
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] ZERO    = DIV_W'(0);

   logic [DIV_W-1:0] cnt_q      [N_CH];
   logic [DIV_W-1:0] cnt_d      [N_CH];
   logic [DIV_W-1:0] div_act_q  [N_CH];
   logic [DIV_W-1:0] div_act_d  [N_CH];
   logic [DIV_W-1:0] div_pend_q [N_CH];
   logic [DIV_W-1:0] div_pend_d [N_CH];
   logic [N_CH-1:0]  pend_q;
   logic [N_CH-1:0]  pend_d;
   logic [N_CH-1:0]  tick_q;
   logic [N_CH-1:0]  tick_d;
   logic [N_CH-1:0]  clk_q;
   logic [N_CH-1:0]  clk_d;
   logic             wr_err_q;
   logic             wr_err_d;
   logic             wr_ok_s;
   logic [N_CH-1:0]  wr_hit_s;
   logic [N_CH-1:0]  term_s;

   // Write qualification: zero divisor or out-of-range channel is rejected.
   always_comb begin
      wr_ok_s  = 1'b0;
      wr_err_d = 1'b0;
      if (wr_en) begin
         if ((wr_div != ZERO) && (int'(wr_ch) < N_CH)) begin
            wr_ok_s = 1'b1;
         end else begin
            wr_err_d = 1'b1;
         end
      end else begin
         wr_ok_s  = 1'b0;
         wr_err_d = 1'b0;
      end
   end

   // Per-channel write hit and terminal-count decode.
   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         wr_hit_s[c] = wr_ok_s && (int'(wr_ch) == c);
         term_s[c]   = (cnt_q[c] == (div_act_q[c] - ONE));
      end
   end

   // Per-channel next state; priority is sync_clr, then disable, then counting.
   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         cnt_d[c]      = cnt_q[c];
         div_act_d[c]  = div_act_q[c];
         div_pend_d[c] = div_pend_q[c];
         pend_d[c]     = pend_q[c];
         tick_d[c]     = 1'b0;
         clk_d[c]      = clk_q[c];

         if (sync_clr) begin
            cnt_d[c]  = ZERO;
            clk_d[c]  = 1'b0;
            pend_d[c] = 1'b0;
            if (wr_hit_s[c]) begin
               div_act_d[c] = wr_div;
            end else if (pend_q[c]) begin
               div_act_d[c] = div_pend_q[c];
            end else begin
               div_act_d[c] = div_act_q[c];
            end
         end else if (!en[c]) begin
            // A divisor change while idle restarts the period so cnt stays below the new D.
            pend_d[c] = 1'b0;
            if (wr_hit_s[c]) begin
               div_act_d[c] = wr_div;
               cnt_d[c]     = ZERO;
            end else if (pend_q[c]) begin
               div_act_d[c] = div_pend_q[c];
               cnt_d[c]     = ZERO;
            end else begin
               div_act_d[c] = div_act_q[c];
               cnt_d[c]     = cnt_q[c];
            end
         end else if (term_s[c]) begin
            cnt_d[c]  = ZERO;
            tick_d[c] = 1'b1;
            clk_d[c]  = ~clk_q[c];
            if (pend_q[c]) begin
               div_act_d[c] = div_pend_q[c];
            end else begin
               div_act_d[c] = div_act_q[c];
            end
            // A write landing on the boundary waits for the next one.
            if (wr_hit_s[c]) begin
               div_pend_d[c] = wr_div;
               pend_d[c]     = 1'b1;
            end else begin
               pend_d[c]     = 1'b0;
            end
         end else begin
            cnt_d[c] = cnt_q[c] + ONE;
            if (wr_hit_s[c]) begin
               div_pend_d[c] = wr_div;
               pend_d[c]     = 1'b1;
            end else begin
               div_pend_d[c] = div_pend_q[c];
               pend_d[c]     = pend_q[c];
            end
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            cnt_q[c]      <= ZERO;
            div_act_q[c]  <= DEF_DIV;
            div_pend_q[c] <= DEF_DIV;
         end
         pend_q   <= '0;
         tick_q   <= '0;
         clk_q    <= '0;
         wr_err_q <= 1'b0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            cnt_q[c]      <= cnt_d[c];
            div_act_q[c]  <= div_act_d[c];
            div_pend_q[c] <= div_pend_d[c];
         end
         pend_q   <= pend_d;
         tick_q   <= tick_d;
         clk_q    <= clk_d;
         wr_err_q <= wr_err_d;
      end
   end

   assign wr_err = wr_err_q;
   assign pend   = pend_q;
   assign tick_o = tick_q;
   assign clk_o  = clk_q;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Self-checking bench for clk_tick_gen: directed scenarios with literal pins, then random stimulus
// checked every cycle against a countdown-style behavioural model.
module tb_clk_tick_gen;

   localparam int N_CH  = 3;
   localparam int DIV_W = 8;
   localparam int CH_W  = 2;
   localparam int DEF_D = 100 / 10 / 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N_CH-1:0]   en;
   logic              sync_clr;
   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [DIV_W-1:0]  wr_div;
   logic              wr_err;
   logic [N_CH-1:0]   pend;
   logic [N_CH-1:0]   tick_o;
   logic [N_CH-1:0]   clk_o;

   always #5 clk = ~clk;

   clk_tick_gen #(
      .N_CH(N_CH), .DIV_W(DIV_W), .INPUT_CLK_FREQ(100), .DEF_OUT_FREQ(10)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
      .wr_err(wr_err), .pend(pend), .tick_o(tick_o), .clk_o(clk_o)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Model: remaining cycles to next tick, active/staged divisor, tick count since clear.
   int m_act [N_CH];
   int m_pv  [N_CH];
   int m_rem [N_CH];
   int m_nt  [N_CH];
   bit m_pend[N_CH];
   bit m_tick[N_CH];
   bit m_err;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_update();
      bit acc, hit;
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            m_act[c] = DEF_D; m_pv[c] = DEF_D; m_rem[c] = DEF_D;
            m_nt[c] = 0; m_pend[c] = 0; m_tick[c] = 0;
         end
         m_err = 0;
      end else begin
         acc   = wr_en && (wr_div != 0) && (int'(wr_ch) < N_CH);
         m_err = wr_en && !acc;
         for (int c = 0; c < N_CH; c++) begin
            hit = acc && (int'(wr_ch) == c);
            if (sync_clr) begin
               if (hit) m_act[c] = int'(wr_div);
               else if (m_pend[c]) m_act[c] = m_pv[c];
               m_pend[c] = 0; m_rem[c] = m_act[c]; m_nt[c] = 0; m_tick[c] = 0;
            end else if (!en[c]) begin
               m_tick[c] = 0;
               if (hit || m_pend[c]) begin
                  m_act[c] = hit ? int'(wr_div) : m_pv[c];
                  m_rem[c] = m_act[c];
               end
               m_pend[c] = 0;
            end else if (m_rem[c] == 1) begin
               m_tick[c] = 1; m_nt[c]++;
               if (m_pend[c]) m_act[c] = m_pv[c];
               m_pend[c] = hit;
               if (hit) m_pv[c] = int'(wr_div);
               m_rem[c] = m_act[c];
            end else begin
               m_tick[c] = 0; m_rem[c]--;
               if (hit) begin m_pv[c] = int'(wr_div); m_pend[c] = 1; end
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [N_CH-1:0] e_tick, e_clk, e_pend;
      for (int c = 0; c < N_CH; c++) begin
         e_tick[c] = m_tick[c];
         e_clk[c]  = m_nt[c][0];
         e_pend[c] = m_pend[c];
      end
      check("tick_o", 32'(tick_o), 32'(e_tick));
      check("clk_o",  32'(clk_o),  32'(e_clk));
      check("pend",   32'(pend),   32'(e_pend));
      check("wr_err", 32'(wr_err), 32'(m_err));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
      cyc++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic write(input int ch, input int d);
      wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = DIV_W'(d);
      step();
      wr_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 3'b111; sync_clr = 1'b0;
      wr_en = 1'b0; wr_ch = 2'd0; wr_div = 8'd0;
      steps(2);
      check("reset_tick", 32'(tick_o), 32'd0);
      check("reset_clk",  32'(clk_o),  32'd0);
      check("reset_pend", 32'(pend),   32'd0);
      check("reset_err",  32'(wr_err), 32'd0);

      // Scenario 1: first tick after 5 edges, all channels in phase.
      rst_n = 1'b1;
      steps(4);
      check("s1_no_tick_yet", 32'(tick_o), 32'd0);
      step();
      check("s1_first_tick", 32'(tick_o), 32'h7);
      check("s1_clk_high",   32'(clk_o),  32'h7);
      steps(4);
      check("s1_gap", 32'(tick_o), 32'd0);
      step();
      check("s1_second_tick", 32'(tick_o), 32'h7);
      check("s1_clk_low",     32'(clk_o),  32'h0);

      // Scenario 2: D=3 to ch1 at cnt=1.
      step();
      write(1, 3);
      check("s2_pend", 32'(pend), 32'h2);
      steps(2);
      check("s2_pend_held", 32'(pend), 32'h2);
      step();
      check("s2_old_period_tick", 32'(tick_o), 32'h7);
      check("s2_pend_clear",      32'(pend),   32'h0);
      steps(3);
      check("s2_new_period_tick", 32'(tick_o), 32'h2);
      steps(9);

      // Scenario 3: illegal writes.
      write(0, 0);
      check("s3_err_zero", 32'(wr_err), 32'd1);
      write(3, 5);
      check("s3_err_chan", 32'(wr_err), 32'd1);
      check("s3_no_pend",  32'(pend),   32'd0);
      step();
      check("s3_err_drop", 32'(wr_err), 32'd0);

      // Scenario 4: D=1 on ch2.
      write(2, 1);
      steps(12);

      // Scenario 5: ch0 paused for 7 cycles.
      en = 3'b110;
      steps(7);
      en = 3'b111;
      steps(12);

      // Scenario 6: sync_clr with ch1 pending D=4, then a one-edge reset.
      write(1, 4);
      sync_clr = 1'b1;
      step();
      sync_clr = 1'b0;
      check("s6_sync_clk",  32'(clk_o),  32'd0);
      check("s6_sync_tick", 32'(tick_o), 32'd0);
      check("s6_sync_pend", 32'(pend),   32'd0);
      steps(3);
      step();
      check("s6_ch1_d4_tick", 32'(tick_o[1]), 32'd1);
      steps(5);
      write(0, 7);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("s6_reset_pend", 32'(pend), 32'd0);
      steps(5);
      check("s6_reset_d5", 32'(tick_o), 32'h7);

      // Random phase.
      for (int i = 0; i < 3000; i++) begin
         rst_n    = ($urandom_range(0, 149) != 0);
         sync_clr = ($urandom_range(0, 39) == 0);
         for (int c = 0; c < N_CH; c++) en[c] = ($urandom_range(0, 7) != 0);
         wr_en = ($urandom_range(0, 5) == 0);
         wr_ch = CH_W'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0:       wr_div = 8'd0;
            1:       wr_div = 8'd1;
            2:       wr_div = DIV_W'($urandom_range(8, 40));
            default: wr_div = DIV_W'($urandom_range(2, 7));
         endcase
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
